// File: rtl/go_pkg.sv
// Shared definitions for the Go turn sequencer: stone colours, pass encoding
// and the one-hot sequencer state type.
package go_pkg;

    localparam logic [1:0] EMPTY     = 2'b00;
    localparam logic [1:0] BLACK     = 2'b01;
    localparam logic [1:0] WHITE     = 2'b10;
    localparam logic [7:0] PASS_MOVE = 8'hFF;
    localparam int         BOARD_DIM = 9;

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_WAIT_MOVE = 6'b000010,
        S_PLACE     = 6'b000100,
        S_WAIT_DONE = 6'b001000,
        S_SWITCH    = 6'b010000,
        S_GAME_OVER = 6'b100000
    } state_t;

endpackage

// File: rtl/go_turn_timer.sv
// Per-turn cycle counter. Expire stays asserted once the limit is reached so a
// turn resumed after an illegal move cannot slip past the deadline.
module go_turn_timer #(
    parameter logic [31:0] TURN_TIMEOUT = 32'd0
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [31:0] cnt;

    always_ff @(posedge clk_in) begin
        if (reset || clear) begin
            cnt <= 32'd0;
        end else if (enable && !expire) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign expire = (TURN_TIMEOUT != 32'd0) && enable && (cnt >= TURN_TIMEOUT - 32'd1);

endmodule

// File: rtl/go_turn_sequencer.sv
// Two-player 9x9 Go turn sequencer: grants turns, forwards moves to the board
// engine, tracks move/pass counts, per-turn timeout and game over.
module go_turn_sequencer
    import go_pkg::*;
#(
    parameter logic [31:0] TURN_TIMEOUT = 32'd0
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic       p0_move_ready,
    input  logic [7:0] p0_move,
    input  logic       p1_move_ready,
    input  logic [7:0] p1_move,
    input  logic       place_done,
    input  logic       place_illegal,
    output logic       p0_my_turn,
    output logic       p1_my_turn,
    output logic       place_req,
    output logic [7:0] place_move,
    output logic [1:0] place_color,
    output logic       illegal_pulse,
    output logic       timeout_pulse,
    output logic [7:0] move_count,
    output logic [1:0] pass_count,
    output logic       game_over
);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state;
    logic [1:0] turn;

    logic       in_wait;
    logic       turn_ready;
    logic [7:0] turn_move;
    logic       move_valid;
    logic       tmr_expire;
    logic       timeout_hit;
    logic       pass_event;
    logic       leave_wait;
    logic       start_ok;
    logic       tmr_clear;

    assign in_wait     = (state == S_WAIT_MOVE);
    assign turn_ready  = (turn == BLACK) ? p0_move_ready : p1_move_ready;
    assign turn_move   = (turn == BLACK) ? p0_move : p1_move;
    assign move_valid  = in_wait && turn_ready;
    // A genuine move on the expiry cycle takes priority over the timeout.
    assign timeout_hit = in_wait && tmr_expire && !turn_ready;
    assign pass_event  = (move_valid && (turn_move == PASS_MOVE)) || timeout_hit;
    assign leave_wait  = move_valid || timeout_hit;
    assign start_ok    = start && ((state == S_IDLE) || (state == S_GAME_OVER));
    assign tmr_clear   = (state == S_SWITCH) || start_ok;

    go_turn_timer #(
        .TURN_TIMEOUT(TURN_TIMEOUT)
    ) u_timer (
        .clk_in(clk_in),
        .reset (reset),
        .clear (tmr_clear),
        .enable(in_wait),
        .expire(tmr_expire)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state         <= S_IDLE;
            turn          <= BLACK;
            p0_my_turn    <= 1'b0;
            p1_my_turn    <= 1'b0;
            place_req     <= 1'b0;
            place_move    <= 8'd0;
            place_color   <= 2'b00;
            illegal_pulse <= 1'b0;
            timeout_pulse <= 1'b0;
            move_count    <= 8'd0;
            pass_count    <= 2'd0;
            game_over     <= 1'b0;
        end else begin
            place_req     <= 1'b0;
            illegal_pulse <= 1'b0;
            timeout_pulse <= 1'b0;
            // my_turn rises one cycle after entering WAIT_MOVE and drops as soon as the turn is used
            p0_my_turn    <= in_wait && !leave_wait && (turn == BLACK);
            p1_my_turn    <= in_wait && !leave_wait && (turn == WHITE);

            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        move_count <= 8'd0;
                        pass_count <= 2'd0;
                        turn       <= BLACK;
                        game_over  <= 1'b0;
                        state      <= S_WAIT_MOVE;
                    end
                end
                S_WAIT_MOVE: begin
                    if (pass_event) begin
                        timeout_pulse <= timeout_hit;
                        pass_count    <= pass_count + 2'd1;
                        if (pass_count == 2'd1) begin
                            game_over <= 1'b1;
                            state     <= S_GAME_OVER;
                        end else begin
                            state <= S_SWITCH;
                        end
                    end else if (move_valid) begin
                        place_move  <= turn_move;
                        place_color <= turn;
                        state       <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    place_req <= 1'b1;
                    state     <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (place_done) begin
                        if (place_illegal) begin
                            illegal_pulse <= 1'b1;
                            state         <= S_WAIT_MOVE;
                        end else begin
                            pass_count <= 2'd0;
                            move_count <= sat_inc8(move_count);
                            state      <= S_SWITCH;
                        end
                    end
                end
                S_SWITCH: begin
                    turn  <= (turn == BLACK) ? WHITE : BLACK;
                    state <= S_WAIT_MOVE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_go_turn_sequencer.sv
// Directed bench for go_turn_sequencer with a 16-cycle turn timeout.
module tb_go_turn_sequencer;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       p0_move_ready = 1'b0;
    logic [7:0] p0_move = 8'd0;
    logic       p1_move_ready = 1'b0;
    logic [7:0] p1_move = 8'd0;
    logic       place_done = 1'b0;
    logic       place_illegal = 1'b0;
    logic       p0_my_turn;
    logic       p1_my_turn;
    logic       place_req;
    logic [7:0] place_move;
    logic [1:0] place_color;
    logic       illegal_pulse;
    logic       timeout_pulse;
    logic [7:0] move_count;
    logic [1:0] pass_count;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    go_turn_sequencer #(
        .TURN_TIMEOUT(32'd16)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .start        (start),
        .p0_move_ready(p0_move_ready),
        .p0_move      (p0_move),
        .p1_move_ready(p1_move_ready),
        .p1_move      (p1_move),
        .place_done   (place_done),
        .place_illegal(place_illegal),
        .p0_my_turn   (p0_my_turn),
        .p1_my_turn   (p1_my_turn),
        .place_req    (place_req),
        .place_move   (place_move),
        .place_color  (place_color),
        .illegal_pulse(illegal_pulse),
        .timeout_pulse(timeout_pulse),
        .move_count   (move_count),
        .pass_count   (pass_count),
        .game_over    (game_over)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_move(input bit pl, input logic [7:0] mv);
        if (pl) begin
            p1_move_ready = 1'b1;
            p1_move       = mv;
        end else begin
            p0_move_ready = 1'b1;
            p0_move       = mv;
        end
        tick();
        p0_move_ready = 1'b0;
        p1_move_ready = 1'b0;
    endtask

    task automatic engine_reply(input bit il);
        place_done    = 1'b1;
        place_illegal = il;
        tick();
        place_done    = 1'b0;
        place_illegal = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({p0_my_turn, p1_my_turn, place_req, illegal_pulse, timeout_pulse, game_over} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {p0_my_turn, p1_my_turn, place_req, illegal_pulse, timeout_pulse, game_over});
        end
        checks++;
        if ({place_move, place_color} !== 10'd0) begin
            errors++;
            $display("FAIL reset_place got %h/%b want 00/00", place_move, place_color);
        end
        checks++;
        if ({move_count, pass_count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", move_count, pass_count);
        end
    endtask

    task automatic test_start_and_legal();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (p0_my_turn !== 1'b0) begin
            errors++;
            $display("FAIL start_early_turn got %b want 0", p0_my_turn);
        end
        tick();
        checks++;
        if ({p0_my_turn, p1_my_turn} !== 2'b10) begin
            errors++;
            $display("FAIL start_turn got %b want 10", {p0_my_turn, p1_my_turn});
        end
        pulse_move(1'b0, 8'h33);
        checks++;
        if ({p0_my_turn, place_req} !== 2'b00) begin
            errors++;
            $display("FAIL accept_drop got %b want 00", {p0_my_turn, place_req});
        end
        tick();
        checks++;
        if ({place_req, place_move, place_color} !== {1'b1, 8'h33, 2'b01}) begin
            errors++;
            $display("FAIL black_req got %b/%h/%b want 1/33/01", place_req, place_move, place_color);
        end
        engine_reply(1'b0);
        checks++;
        if ({place_req, move_count} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL black_done got %b/%0d want 0/1", place_req, move_count);
        end
        tick();
        checks++;
        if (p1_my_turn !== 1'b0) begin
            errors++;
            $display("FAIL white_early_turn got %b want 0", p1_my_turn);
        end
        tick();
        checks++;
        if ({p0_my_turn, p1_my_turn} !== 2'b01) begin
            errors++;
            $display("FAIL white_turn got %b want 01", {p0_my_turn, p1_my_turn});
        end
    endtask

    task automatic test_ignore_and_illegal();
        pulse_move(1'b0, 8'h44);
        checks++;
        if ({p0_my_turn, p1_my_turn} !== 2'b01) begin
            errors++;
            $display("FAIL ignore_turn got %b want 01", {p0_my_turn, p1_my_turn});
        end
        tick();
        checks++;
        if (place_req !== 1'b0) begin
            errors++;
            $display("FAIL ignore_req got %b want 0", place_req);
        end
        pulse_move(1'b1, 8'h44);
        tick();
        checks++;
        if ({place_req, place_move, place_color} !== {1'b1, 8'h44, 2'b10}) begin
            errors++;
            $display("FAIL white_req got %b/%h/%b want 1/44/10", place_req, place_move, place_color);
        end
        engine_reply(1'b1);
        checks++;
        if ({illegal_pulse, move_count} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL illegal got %b/%0d want 1/1", illegal_pulse, move_count);
        end
        tick();
        checks++;
        if ({p0_my_turn, p1_my_turn, illegal_pulse} !== 3'b010) begin
            errors++;
            $display("FAIL illegal_retry got %b want 010", {p0_my_turn, p1_my_turn, illegal_pulse});
        end
    endtask

    task automatic test_double_pass();
        pulse_move(1'b1, 8'h55);
        tick();
        engine_reply(1'b0);
        checks++;
        if (move_count !== 8'd2) begin
            errors++;
            $display("FAIL second_move got %0d want 2", move_count);
        end
        tick();
        tick();
        pulse_move(1'b0, 8'hFF);
        checks++;
        if ({pass_count, game_over} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL first_pass got %0d/%b want 1/0", pass_count, game_over);
        end
        tick();
        tick();
        checks++;
        if (p1_my_turn !== 1'b1) begin
            errors++;
            $display("FAIL pass_switch got %b want 1", p1_my_turn);
        end
        pulse_move(1'b1, 8'hFF);
        checks++;
        if ({pass_count, game_over} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL second_pass got %0d/%b want 2/1", pass_count, game_over);
        end
        tick();
        checks++;
        if ({p0_my_turn, p1_my_turn, place_req, game_over} !== 4'b0001) begin
            errors++;
            $display("FAIL game_over_hold got %b want 0001", {p0_my_turn, p1_my_turn, place_req, game_over});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({move_count, pass_count, game_over} !== 11'd0) begin
            errors++;
            $display("FAIL restart_clear got %0d/%0d/%b want 0/0/0", move_count, pass_count, game_over);
        end
        tick();
        checks++;
        if ({p0_my_turn, p1_my_turn} !== 2'b10) begin
            errors++;
            $display("FAIL restart_turn got %b want 10", {p0_my_turn, p1_my_turn});
        end
    endtask

    task automatic test_pass_legal_pass();
        pulse_move(1'b0, 8'hFF);
        checks++;
        if (pass_count !== 2'd1) begin
            errors++;
            $display("FAIL plp_pass1 got %0d want 1", pass_count);
        end
        tick();
        tick();
        pulse_move(1'b1, 8'h66);
        tick();
        engine_reply(1'b0);
        checks++;
        if ({pass_count, move_count} !== {2'd0, 8'd1}) begin
            errors++;
            $display("FAIL plp_legal got %0d/%0d want 0/1", pass_count, move_count);
        end
        tick();
        tick();
        pulse_move(1'b0, 8'hFF);
        checks++;
        if ({pass_count, game_over} !== {2'd1, 1'b0}) begin
            errors++;
            $display("FAIL plp_pass2 got %0d/%b want 1/0", pass_count, game_over);
        end
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        checks++;
        if ({timeout_pulse, pass_count} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_early got %b/%0d want 0/0", timeout_pulse, pass_count);
        end
        tick();
        checks++;
        if ({timeout_pulse, pass_count, p0_my_turn} !== {1'b1, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL timeout_fire got %b/%0d/%b want 1/1/0", timeout_pulse, pass_count, p0_my_turn);
        end
        tick();
        checks++;
        if (timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL timeout_single got %b want 0", timeout_pulse);
        end
        tick();
        checks++;
        if (p1_my_turn !== 1'b1) begin
            errors++;
            $display("FAIL timeout_switch got %b want 1", p1_my_turn);
        end
        repeat (14) tick();
        pulse_move(1'b1, 8'h22);
        checks++;
        if ({timeout_pulse, pass_count, p1_my_turn} !== {1'b0, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL expiry_move got %b/%0d/%b want 0/1/0", timeout_pulse, pass_count, p1_my_turn);
        end
        tick();
        checks++;
        if ({place_req, place_move, place_color} !== {1'b1, 8'h22, 2'b10}) begin
            errors++;
            $display("FAIL expiry_req got %b/%h/%b want 1/22/10", place_req, place_move, place_color);
        end
        engine_reply(1'b0);
        checks++;
        if ({move_count, pass_count} !== {8'd1, 2'd0}) begin
            errors++;
            $display("FAIL expiry_done got %0d/%0d want 1/0", move_count, pass_count);
        end
    endtask

    task automatic test_reset_in_wait_done();
        tick();
        tick();
        pulse_move(1'b0, 8'h77);
        tick();
        checks++;
        if (place_req !== 1'b1) begin
            errors++;
            $display("FAIL rwd_req got %b want 1", place_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({p0_my_turn, p1_my_turn, place_req, place_move, place_color, move_count, pass_count, game_over} !== 24'd0) begin
            errors++;
            $display("FAIL rwd_clear got %b/%b/%b/%h/%b/%0d/%0d/%b want all 0",
                     p0_my_turn, p1_my_turn, place_req, place_move, place_color, move_count, pass_count, game_over);
        end
        place_done = 1'b1;
        tick();
        place_done = 1'b0;
        checks++;
        if ({move_count, illegal_pulse} !== 9'd0) begin
            errors++;
            $display("FAIL late_done got %0d/%b want 0/0", move_count, illegal_pulse);
        end
        tick();
        checks++;
        if ({p0_my_turn, p1_my_turn, place_req} !== 3'b000) begin
            errors++;
            $display("FAIL late_done_idle got %b want 000", {p0_my_turn, p1_my_turn, place_req});
        end
    endtask

    task automatic test_saturation();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 255; i++) begin
            pulse_move((i % 2) == 1, 8'h11);
            tick();
            engine_reply(1'b0);
            tick();
            tick();
        end
        checks++;
        if (move_count !== 8'hFF) begin
            errors++;
            $display("FAIL sat_reach got %0d want 255", move_count);
        end
        pulse_move(1'b1, 8'h12);
        tick();
        engine_reply(1'b0);
        checks++;
        if ({move_count, pass_count} !== {8'hFF, 2'd0}) begin
            errors++;
            $display("FAIL sat_hold got %0d/%0d want 255/0", move_count, pass_count);
        end
    endtask

    initial begin
        test_reset();
        test_start_and_legal();
        test_ignore_and_illegal();
        test_double_pass();
        test_pass_legal_pass();
        test_timeout();
        test_reset_in_wait_done();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
